// File: rtl/bifurcation_sweep_pkg.sv
// Shared types and constants for the bifurcation sweep controller.
// Holds the FSM state encoding and the Q-format defaults.
package bifurcation_sweep_pkg;

    localparam int MU_W_DEF  = 18;
    localparam int X_W_DEF   = 17;
    localparam int IDX_W_DEF = 10;
    localparam int TMO_W_DEF = 20;

    // 1.0 in the unsigned Q2.16 mu format
    localparam logic [17:0] MU_ONE = 18'h1_0000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_DONE = 3'd3,
        EMIT      = 3'd4,
        FINISH    = 3'd5
    } state_t;

endpackage

// File: rtl/bifurcation_sweep_sat_add.sv
// Unsigned adder that clamps at all-ones instead of wrapping.
// sat_o flags that the clamp was applied.
module sat_add #(
    parameter int W = 18
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         sat_o
);

    logic [W:0] full;

    assign full  = {1'b0, a_i} + {1'b0, b_i};
    assign sat_o = full[W];
    assign sum_o = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/bifurcation_sweep.sv
// Steps mu across a range, runs the external map iterator per point,
// and streams (mu, x, idx) samples out through a valid/ready port.
module bifurcation_sweep
    import bifurcation_sweep_pkg::*;
#(
    parameter int MU_W  = MU_W_DEF,
    parameter int X_W   = X_W_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int TMO_W = TMO_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [MU_W-1:0]  mu_start,
    input  logic [MU_W-1:0]  mu_step,
    input  logic [IDX_W-1:0] mu_count,
    input  logic [X_W-1:0]   x0,
    input  logic [X_W-1:0]   iter_times,
    output logic             map_dset,
    output logic [X_W-1:0]   map_dzero,
    output logic [X_W-1:0]   map_times,
    output logic [MU_W-1:0]  map_mu,
    input  logic             map_done,
    input  logic [X_W-1:0]   map_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MU_W-1:0]  out_mu,
    output logic [X_W-1:0]   out_x,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy,
    output logic             sweep_done,
    output logic             mu_sat,
    output logic             timeout_err
);

    // Watchdog fires on the cycle its count would reach all-ones
    localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t state_q, state_d;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [MU_W-1:0]  mu_cur_q, mu_cur_d;
    logic [MU_W-1:0]  step_q, step_d;
    logic [X_W-1:0]   x0_q, x0_d;
    logic [X_W-1:0]   iter_q, iter_d;
    logic [X_W-1:0]   ox_q, ox_d;
    logic [MU_W-1:0]  omu_q, omu_d;
    logic [IDX_W-1:0] oidx_q, oidx_d;
    logic             sat_q, sat_d;
    logic             tmo_q, tmo_d;
    logic [TMO_W-1:0] wd_q, wd_d;

    logic [MU_W-1:0]  mu_sum;
    logic             mu_ovf;
    logic             idx_last;
    logic             wd_hit;

    sat_add #(
        .W (MU_W)
    ) u_sat_add (
        .a_i   (mu_cur_q),
        .b_i   (step_q),
        .sum_o (mu_sum),
        .sat_o (mu_ovf)
    );

    assign idx_last = (idx_q == count_q - IDX_W'(1));
    assign wd_hit   = (wd_q == WD_LAST);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        mu_cur_d = mu_cur_q;
        step_d   = step_q;
        x0_d     = x0_q;
        iter_d   = iter_q;
        ox_d     = ox_q;
        omu_d    = omu_q;
        oidx_d   = oidx_q;
        sat_d    = sat_q;
        tmo_d    = tmo_q;
        wd_d     = wd_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sat_d = 1'b0;
                    tmo_d = 1'b0;
                    if (mu_count != '0) begin
                        step_d   = mu_step;
                        count_d  = mu_count;
                        x0_d     = x0;
                        iter_d   = iter_times;
                        idx_d    = '0;
                        mu_cur_d = mu_start;
                        state_d  = LOAD;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            LOAD: begin
                wd_d    = '0;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                wd_d = wd_q + 1'b1;
                // a done level still high from the previous point is stale
                if (!map_done) begin
                    state_d = WAIT_DONE;
                end else if (wd_hit) begin
                    tmo_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            WAIT_DONE: begin
                wd_d = wd_q + 1'b1;
                if (map_done) begin
                    ox_d    = map_result;
                    omu_d   = mu_cur_q;
                    oidx_d  = idx_q;
                    state_d = EMIT;
                end else if (wd_hit) begin
                    tmo_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx_last) begin
                        state_d = FINISH;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        mu_cur_d = mu_sum;
                        state_d  = LOAD;
                        if (mu_ovf) begin
                            sat_d = 1'b1;
                        end
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            count_q  <= '0;
            mu_cur_q <= '0;
            step_q   <= '0;
            x0_q     <= '0;
            iter_q   <= '0;
            ox_q     <= '0;
            omu_q    <= '0;
            oidx_q   <= '0;
            sat_q    <= 1'b0;
            tmo_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            mu_cur_q <= mu_cur_d;
            step_q   <= step_d;
            x0_q     <= x0_d;
            iter_q   <= iter_d;
            ox_q     <= ox_d;
            omu_q    <= omu_d;
            oidx_q   <= oidx_d;
            sat_q    <= sat_d;
            tmo_q    <= tmo_d;
            wd_q     <= wd_d;
        end
    end

    // Map operands come straight from latched state, so they stay stable
    assign map_dset    = (state_q == LOAD);
    assign map_mu      = mu_cur_q;
    assign map_dzero   = x0_q;
    assign map_times   = iter_q;
    assign out_valid   = (state_q == EMIT);
    assign out_mu      = omu_q;
    assign out_x       = ox_q;
    assign out_idx     = oidx_q;
    assign busy        = (state_q != IDLE);
    assign sweep_done  = (state_q == FINISH);
    assign mu_sat      = sat_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_bifurcation_sweep.sv
// Randomized scoreboard bench for bifurcation_sweep with a
// behavioural map iterator and an independent sample monitor.
module tb_bifurcation_sweep;

    localparam int MU_W  = 18;
    localparam int X_W   = 17;
    localparam int IDX_W = 10;
    localparam int TMO_W = 6;
    localparam longint MU_MAX = 64'h3FFFF;

    logic             CLK;
    logic             RST_N;
    logic             start;
    logic [MU_W-1:0]  mu_start;
    logic [MU_W-1:0]  mu_step;
    logic [IDX_W-1:0] mu_count;
    logic [X_W-1:0]   x0;
    logic [X_W-1:0]   iter_times;
    logic             map_dset;
    logic [X_W-1:0]   map_dzero;
    logic [X_W-1:0]   map_times;
    logic [MU_W-1:0]  map_mu;
    logic             map_done;
    logic [X_W-1:0]   map_result;
    logic             out_valid;
    logic             out_ready;
    logic [MU_W-1:0]  out_mu;
    logic [X_W-1:0]   out_x;
    logic [IDX_W-1:0] out_idx;
    logic             busy;
    logic             sweep_done;
    logic             mu_sat;
    logic             timeout_err;

    bifurcation_sweep #(
        .MU_W  (MU_W),
        .X_W   (X_W),
        .IDX_W (IDX_W),
        .TMO_W (TMO_W)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .mu_start    (mu_start),
        .mu_step     (mu_step),
        .mu_count    (mu_count),
        .x0          (x0),
        .iter_times  (iter_times),
        .map_dset    (map_dset),
        .map_dzero   (map_dzero),
        .map_times   (map_times),
        .map_mu      (map_mu),
        .map_done    (map_done),
        .map_result  (map_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_mu      (out_mu),
        .out_x       (out_x),
        .out_idx     (out_idx),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .mu_sat      (mu_sat),
        .timeout_err (timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [MU_W-1:0]  mu;
        logic [X_W-1:0]   x;
        logic [IDX_W-1:0] idx;
    } smp_t;

    smp_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    int rdy_mode = 0;
    int hold_left = 0;
    int max_hold = 0;
    int fixed_lat = 0;
    bit stuck = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Stand-in for the iterator: an arbitrary but deterministic function
    function automatic logic [X_W-1:0] fake(input logic [MU_W-1:0] mu,
                                            input logic [X_W-1:0] xv,
                                            input logic [X_W-1:0] it);
        logic [X_W-1:0] t;
        t = mu[16:0] ^ xv ^ {16'd0, mu[17]};
        return t + it;
    endfunction

    // Behavioural map iterator: done drops on dset, rises after a latency
    int m_cnt;
    always @(posedge CLK) begin
        if (!RST_N) begin
            map_done   <= 1'b0;
            map_result <= '0;
            m_cnt      <= 0;
        end else if (stuck) begin
            map_done <= 1'b1;
            m_cnt    <= 0;
        end else if (map_dset) begin
            map_done   <= 1'b0;
            m_cnt      <= (fixed_lat != 0) ? fixed_lat
                                           : int'($urandom_range(1, 6));
            map_result <= fake(map_mu, map_dzero, map_times);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) map_done <= 1'b1;
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid && hold_left > 0) begin
                        out_ready = 1'b0;
                        hold_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each transfer, checks EMIT holds
    initial begin
        bit prev_held;
        int hold_len;
        logic [MU_W-1:0] h_mu;
        logic [X_W-1:0] h_x;
        logic [IDX_W-1:0] h_idx;
        smp_t e;
        prev_held = 1'b0;
        hold_len = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                prev_held = 1'b0;
                hold_len = 0;
            end else begin
                if (map_dset) chk("dset_during_emit", 64'(out_valid), 64'd0);
                if (prev_held) begin
                    chk("valid_hold", 64'(out_valid), 64'd1);
                    if (out_valid) begin
                        chk("hold_mu", 64'(out_mu), 64'(h_mu));
                        chk("hold_x", 64'(out_x), 64'(h_x));
                        chk("hold_idx", 64'(out_idx), 64'(h_idx));
                    end
                end
                prev_held = 1'b0;
                if (out_valid) begin
                    hold_len++;
                    if (out_ready) begin
                        n_chk++;
                        if (q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_sample: got idx %0d required none",
                                     out_idx);
                        end else begin
                            n_chk--;
                            e = q.pop_front();
                            chk("out_mu", 64'(out_mu), 64'(e.mu));
                            chk("out_x", 64'(out_x), 64'(e.x));
                            chk("out_idx", 64'(out_idx), 64'(e.idx));
                        end
                        if (hold_len > max_hold) max_hold = hold_len;
                        hold_len = 0;
                    end else begin
                        prev_held = 1'b1;
                        h_mu = out_mu;
                        h_x = out_x;
                        h_idx = out_idx;
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [MU_W-1:0] ms, input logic [MU_W-1:0] st,
                            input logic [IDX_W-1:0] cnt, input logic [X_W-1:0] xv,
                            input logic [X_W-1:0] itv);
        smp_t e;
        longint m;
        for (int i = 0; i < int'(cnt); i++) begin
            m = longint'(ms) + longint'(i) * longint'(st);
            if (m > MU_MAX) m = MU_MAX;
            e.mu = MU_W'(m);
            e.x = fake(e.mu, xv, itv);
            e.idx = IDX_W'(i);
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && busy; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic run_sweep(input logic [MU_W-1:0] ms, input logic [MU_W-1:0] st,
                             input logic [IDX_W-1:0] cnt, input logic [X_W-1:0] xv,
                             input logic [X_W-1:0] itv, input bit exp_tmo,
                             input string tag);
        int dsets, waits, ncyc;
        bit seen, esat;
        wait_idle();
        if (!exp_tmo) push_exp(ms, st, cnt, xv, itv);
        esat = !exp_tmo && cnt >= 2 &&
               (longint'(ms) + longint'(int'(cnt) - 1) * longint'(st) > MU_MAX);
        mu_start = ms;
        mu_step = st;
        mu_count = cnt;
        x0 = xv;
        iter_times = itv;
        start = 1'b1;
        seen = 1'b0;
        dsets = 0;
        waits = 0;
        ncyc = -1;
        for (int k = 0; k < 3000; k++) begin
            @(posedge CLK);
            #1;
            if (map_dset) dsets++;
            if (sweep_done) begin
                seen = 1'b1;
                ncyc = k;
                break;
            end
            if (busy && !map_dset) waits++;
            // stray starts and config churn while busy must be ignored
            start = busy && ($urandom_range(0, 7) == 0);
            mu_count = IDX_W'($urandom);
            mu_start = MU_W'($urandom);
            mu_step = MU_W'($urandom);
            x0 = X_W'($urandom);
            iter_times = X_W'($urandom);
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_dset_count"}, 64'(dsets), exp_tmo ? 64'd1 : 64'(cnt));
        chk({tag, "_pending"}, 64'(q.size()), 64'd0);
        chk({tag, "_mu_sat"}, 64'(mu_sat), 64'(esat));
        chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(exp_tmo));
        if (exp_tmo) chk({tag, "_wait_cycles"}, 64'(waits), 64'd63);
        if (cnt == 0) chk({tag, "_done_latency"}, 64'(ncyc), 64'd0);
        q.delete();
        @(posedge CLK);
        #1;
        chk({tag, "_done_pulse"}, 64'(sweep_done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 64'({map_dset, out_valid, busy, sweep_done,
                                mu_sat, timeout_err}), 64'd0);
        chk({tag, "_map"}, 64'({map_mu, map_dzero, map_times}), 64'd0);
        chk({tag, "_out"}, 64'({out_mu, out_x, out_idx}), 64'd0);
    endtask

    initial begin
        bit found;
        RST_N = 1'b0;
        start = 1'b0;
        mu_start = '0;
        mu_step = '0;
        mu_count = '0;
        x0 = '0;
        iter_times = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_zero("reset");
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("first_cycle_idle", 64'(busy), 64'd0);

        rdy_mode = 0;
        fixed_lat = 5;
        run_sweep(18'h2_0000, 18'h0_4000, 10'd3, 17'h00123, 17'd100, 1'b0, "basic");
        run_sweep(18'h3_F000, 18'h0_8000, 10'd2, 17'h1ABCD, 17'd7, 1'b0, "sat");

        rdy_mode = 2;
        hold_left = 10;
        max_hold = 0;
        run_sweep(18'h0_8000, 18'h0_0100, 10'd2, 17'h05555, 17'd3, 1'b0, "hold");
        chk("hold_len", 64'(max_hold), 64'd11);

        rdy_mode = 0;
        run_sweep(18'h1_2345, 18'h0_0001, 10'd0, 17'h0, 17'd1, 1'b0, "zero");

        rdy_mode = 1;
        fixed_lat = 0;
        for (int n = 0; n < 10; n++) begin
            run_sweep(MU_W'($urandom),
                      ($urandom_range(0, 3) == 0) ? MU_W'($urandom) : MU_W'($urandom_range(0, 'h1000)),
                      IDX_W'($urandom_range(1, 5)), X_W'($urandom), X_W'($urandom),
                      1'b0, "rand");
        end

        stuck = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        run_sweep(18'h1_0000, 18'h0_1000, 10'd3, 17'h0F0F0, 17'd9, 1'b1, "tmo");
        stuck = 1'b0;
        run_sweep(18'h0_1000, 18'h0_2000, 10'd2, 17'h0AAAA, 17'd5, 1'b0, "post_tmo");

        rdy_mode = 3;
        out_ready = 1'b0;
        fixed_lat = 3;
        wait_idle();
        push_exp(18'h1_0000, 18'h0_1000, 10'd4, 17'h01234, 17'd11);
        mu_start = 18'h1_0000;
        mu_step = 18'h0_1000;
        mu_count = 10'd4;
        x0 = 17'h01234;
        iter_times = 17'd11;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge CLK);
            #1;
            if (out_valid && out_idx == 10'd0) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_reach_p0", 64'(found), 64'd1);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge CLK);
            #1;
            if (out_valid && out_idx == 10'd1) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_reach_p1", 64'(found), 64'd1);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        check_zero("rst_emit");
        q.delete();
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_emit_idle", 64'({busy, out_valid}), 64'd0);

        rdy_mode = 0;
        run_sweep(18'h0_4000, 18'h0_4000, 10'd2, 17'h00777, 17'd2, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "global timeout");
    end

endmodule
